// File: rtl/test_finisher_device.sv
`default_nettype none
// ============================================================================
// Module      : test_finisher_device
// Description : Memory-mapped finisher. Software writes a pass (0x5555) or
//               fail (0x3333, code in [31:16]) command to the FINISHER
//               register. After a drain period a sticky finish indication
//               is raised for the testbench top.
// Ports       : clock, reset       - clock, synchronous active-high reset
//               req_*              - request channel (valid/ready, one at a time)
//               resp_*             - response channel (valid/ready, held stable)
//               finish_valid/fail/code - sticky finish indication
// Registers   : word 0 FINISHER (R/W, full-word writes only)
//               word 1 STATUS   (RO: bit0 armed, bit1 done, bit2 fail,
//                                [31:16] code)
// Revision    : 1.0 - initial release
// ============================================================================
module test_finisher_device #(
    parameter int ADDR_W       = 12,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              finish_valid,
    output logic              finish_fail,
    output logic [15:0]       finish_code
);

    localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_drain_load = CNT_W'(DRAIN_CYCLES);

    localparam logic [1:0] c_f_run   = 2'd0;
    localparam logic [1:0] c_f_drain = 2'd1;
    localparam logic [1:0] c_f_done  = 2'd2;

    localparam logic c_b_idle = 1'b0;
    localparam logic c_b_resp = 1'b1;

    logic [1:0]        r_fstate, w_fstate_nxt;
    logic              r_bstate, w_bstate_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_finisher;
    logic              r_fail;
    logic [15:0]       r_code;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_error;

    logic              w_accept;
    logic [ADDR_W-1:0] w_word;
    logic              w_is_fin, w_is_stat, w_full;
    logic              w_fin_wr, w_cmd_pass, w_cmd_fail, w_cmd;
    logic [15:0]       w_fail_code;
    logic              w_armed, w_done;
    logic [31:0]       w_status;

    // Word index; shifting the whole address keeps the low byte bits
    // explicitly ignored.
    assign w_word      = req_addr >> 2;
    assign w_is_fin    = (w_word == '0);
    assign w_is_stat   = (w_word == ADDR_W'(1));
    assign w_full      = (req_wmask == 4'hF);
    assign w_accept    = req_valid && (r_bstate == c_b_idle);
    assign w_fin_wr    = w_accept && req_write && w_is_fin && w_full;
    assign w_cmd_pass  = (req_wdata[15:0] == 16'h5555);
    assign w_cmd_fail  = (req_wdata[15:0] == 16'h3333);
    assign w_cmd       = w_fin_wr && (w_cmd_pass || w_cmd_fail);
    // A failure must never be reported with the pass code.
    assign w_fail_code = (req_wdata[31:16] == 16'h0) ? 16'h1 : req_wdata[31:16];

    assign w_armed  = (r_fstate != c_f_run);
    assign w_done   = (r_fstate == c_f_done);
    assign w_status = {r_code, 13'b0, r_fail, w_done, w_armed};

    // ---------------- finish FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fstate <= c_f_run;
        end else begin
            r_fstate <= w_fstate_nxt;
        end
    end

    always_comb begin
        w_fstate_nxt = r_fstate;
        case (r_fstate)
            c_f_run: begin
                if (w_cmd) begin
                    w_fstate_nxt = (DRAIN_CYCLES == 0) ? c_f_done : c_f_drain;
                end
            end
            c_f_drain: begin
                // Leave on the decrement that reaches zero so finish_valid
                // appears exactly DRAIN_CYCLES cycles after the drain starts.
                if (r_cnt <= CNT_W'(1)) begin
                    w_fstate_nxt = c_f_done;
                end
            end
            c_f_done: w_fstate_nxt = c_f_done;
            default:  w_fstate_nxt = c_f_run;
        endcase
    end

    always_comb begin
        finish_valid = w_done;
        finish_fail  = r_fail;
        finish_code  = r_code;
    end

    // Drain counter and latched result; only the first command is latched.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_fail <= 1'b0;
            r_code <= 16'h0;
        end else begin
            if ((r_fstate == c_f_run) && w_cmd) begin
                r_cnt  <= c_drain_load;
                r_fail <= w_cmd_fail;
                r_code <= w_cmd_fail ? w_fail_code : 16'h0;
            end else if ((r_fstate == c_f_drain) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ---------------- bus FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bstate <= c_b_idle;
        end else begin
            r_bstate <= w_bstate_nxt;
        end
    end

    always_comb begin
        w_bstate_nxt = r_bstate;
        case (r_bstate)
            c_b_idle: if (req_valid)  w_bstate_nxt = c_b_resp;
            c_b_resp: if (resp_ready) w_bstate_nxt = c_b_idle;
            default:  w_bstate_nxt = c_b_idle;
        endcase
    end

    always_comb begin
        req_ready  = (r_bstate == c_b_idle);
        resp_valid = (r_bstate == c_b_resp);
        resp_rdata = r_resp_rdata;
        resp_error = r_resp_error;
    end

    // Register file and response capture at request acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_finisher   <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_resp_error <= 1'b0;
        end else if (w_accept) begin
            r_resp_rdata <= 32'h0;
            r_resp_error <= 1'b0;
            if (req_write) begin
                if (w_is_fin && w_full) begin
                    r_finisher <= req_wdata;
                end else begin
                    r_resp_error <= 1'b1;
                end
            end else if (w_is_fin) begin
                r_resp_rdata <= r_finisher;
            end else if (w_is_stat) begin
                r_resp_rdata <= w_status;
            end else begin
                r_resp_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/test_finisher_device.md
# test_finisher_device

Memory-mapped responder that lets software running on the DUT finish a simulation from the RTL side, complementing the testbench hook that DPI agents call. The core writes a finisher register over a simple request/response bus. The block decodes the pass/fail command, waits a programmable drain period so in-flight prints and trace can flush, then raises a sticky finish indication carrying the exit code. The testbench top samples that indication and ends the run.

## Interface
- ADDR_W, 12: request address width in bits (byte address; minimum 4).
- DRAIN_CYCLES, 16: cycles between command acceptance and `finish_valid`; 0 is legal.
- clock  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2]; bits [1:0] ignored.
- req_wdata  input  32  write data.
- req_wmask  input  4  byte enables for writes.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_error  output  1  request rejected (bad address or partial finisher write).
- finish_valid  output  1  sticky; the test is over.
- finish_fail  output  1  valid with `finish_valid`; 1 = failure.
- finish_code  output  16  valid with `finish_valid`; 0 on pass, nonzero on fail.

## Operation
- Registers, by word index:
  - 0 = FINISHER (R/W).
  - 1 = STATUS (RO): bit0 armed, bit1 done, bit2 fail, [31:16] code, others 0.
  - Any other index: `resp_error` = 1, no side effect.
- FINISHER write with `req_wmask` = 4'b1111: stores `req_wdata`, then decodes the low 16 bits:
  - 0x5555: pass, code 0.
  - 0x3333: fail, code = `req_wdata[31:16]`; a code of 0 is forced to 1.
  - Any other value: stored only, no command, OKAY response.
- FINISHER write with any other mask: `resp_error` = 1, no store, no command.
- FINISHER read: returns the last stored value (reset 0).
- Writes to STATUS: `resp_error` = 1.
- Finish FSM:
  - RUN → DRAIN when a pass/fail command is accepted. Latches fail/code and loads the counter with DRAIN_CYCLES.
  - DRAIN: counter decrements each cycle. → DONE when the counter is 0 (immediately if DRAIN_CYCLES = 0).
  - DONE: terminal until reset.
- First command wins. Commands in DRAIN/DONE are still stored and get an OKAY response, but latched fail/code are unchanged.
- Armed = state ≠ RUN; done = state == DONE.
- Bus FSM, at most one outstanding request:
  - IDLE: `req_ready` = 1.
  - RESP: `req_ready` = 0, `resp_valid` = 1, response fields held stable until `resp_ready`.
- Counter width = clog2(DRAIN_CYCLES+1), minimum 1 bit; no wrap (it stops at 0).

## Timing
- Reset values: `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_error` 0, `finish_valid` 0, `finish_fail` 0, `finish_code` 0, FINISHER 0, finish FSM RUN, counter 0.
- Request accepted at edge T (`req_valid` && `req_ready`):
  - `resp_valid` = 1 from cycle T+1.
  - `req_ready` = 0 from T+1 until the response handshake completes.
- Response handshake at edge R (`resp_valid` && `resp_ready`): `req_ready` = 1 from R+1. No same-cycle request acceptance; back-to-back throughput is 1 request per 2 cycles.
- Command accepted at edge T: STATUS.armed reads 1 for any read accepted at T+1 or later.
- `finish_valid` rises in cycle T+1+DRAIN_CYCLES and stays high until reset; `finish_fail`/`finish_code` are stable from the same cycle.
- `finish_valid` is independent of the response: it may assert while `resp_ready` is held low.
- Reset during DRAIN, DONE, or a pending response: everything returns to reset values next cycle; the pending response is dropped.
- Reset has priority over a simultaneous request.

## Test plan
- Pass command: write 0x0000_5555 to 0x000, mask F, DRAIN=16, accepted at T → OKAY response at T+1; `finish_valid`=1, `finish_fail`=0, `finish_code`=0 at T+17; STATUS read during drain = 0x0000_0001, after done = 0x0000_0003.
- Fail command: write 0x002A_3333 → `finish_fail`=1, `finish_code`=0x002A; STATUS = 0x002A_0007. Write 0x0000_3333 → code forced to 0x0001.
- First wins: 0x0007_3333 then 0x0000_5555 during drain → both OKAY; FINISHER reads 0x0000_5555; finish reports fail with code 7.
- Errors: partial mask 4'b0011 to 0x000, write to 0x004, read from 0x008 → each `resp_error`=1, `resp_rdata`=0, FSM stays RUN.
- Backpressure: hold `resp_ready`=0 for 10 cycles → `req_ready`=0 and response fields stable throughout. With DRAIN_CYCLES=0, `finish_valid` still rises at T+1.
- Reset mid-drain: assert `reset` 5 cycles after a fail command → all outputs at reset values; a new pass command then completes normally.
